// File: rtl/operand_fetch.sv
// operand_fetch: sequencer that reads one or two operands from the 8x32
// operand SRAM through its registered read port and hands them to the ALU
// stage with a valid/ready handshake. It also flags operands taken from
// empty slots.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   unary,
  input  logic [ADDR_W-1:0]      addrA,
  input  logic [ADDR_W-1:0]      addrB,
  input  logic [DATA_W-1:0]      sramData,
  input  logic [(2**ADDR_W)-1:0] slotEmpty,
  input  logic                   aluReady,
  output logic                   RD,
  output logic [ADDR_W-1:0]      Address,
  output logic [DATA_W-1:0]      opA,
  output logic [DATA_W-1:0]      opB,
  output logic                   opValid,
  output logic                   emptyErr,
  output logic                   busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ_A = 3'd1,
    CAP_A = 3'd2,
    CAP_B = 3'd3,
    VALID = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic                op_valid_q, op_valid_d;
  logic                empty_err_q, empty_err_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
  logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
  logic                unary_q, unary_d;

  // Next-state and next-output logic. The SRAM returns data one cycle after
  // the address is presented, so operand A is captured while operand B's
  // read is already in flight.
  always_comb begin
    state_d     = state_q;
    rd_d        = 1'b0;
    address_d   = address_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    op_valid_d  = op_valid_q;
    empty_err_d = empty_err_q;
    busy_d      = busy_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    unary_d     = unary_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_a_d    = addrA;
          addr_b_d    = addrB;
          unary_d     = unary;
          empty_err_d = slotEmpty[addrA] | (~unary & slotEmpty[addrB]);
          address_d   = addrA;
          rd_d        = 1'b1;
          busy_d      = 1'b1;
          state_d     = REQ_A;
        end else begin
          rd_d = 1'b0;
        end
      end
      REQ_A: begin
        state_d = CAP_A;
        if (!unary_q) begin
          address_d = addr_b_q;
          rd_d      = 1'b1;
        end else begin
          rd_d = 1'b0;
        end
      end
      CAP_A: begin
        opa_d = sramData;
        rd_d  = 1'b0;
        if (unary_q) begin
          opb_d      = {DATA_W{1'b0}};
          op_valid_d = 1'b1;
          state_d    = VALID;
        end else begin
          state_d = CAP_B;
        end
      end
      CAP_B: begin
        opb_d      = sramData;
        op_valid_d = 1'b1;
        state_d    = VALID;
      end
      VALID: begin
        // start is deliberately ignored here; a new request must come from IDLE.
        if (aluReady) begin
          op_valid_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          op_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        op_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any fetch immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      address_q   <= {ADDR_W{1'b0}};
      opa_q       <= {DATA_W{1'b0}};
      opb_q       <= {DATA_W{1'b0}};
      op_valid_q  <= 1'b0;
      empty_err_q <= 1'b0;
      busy_q      <= 1'b0;
      addr_a_q    <= {ADDR_W{1'b0}};
      addr_b_q    <= {ADDR_W{1'b0}};
      unary_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      address_q   <= address_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      op_valid_q  <= op_valid_d;
      empty_err_q <= empty_err_d;
      busy_q      <= busy_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      unary_q     <= unary_d;
    end
  end

  assign RD       = rd_q;
  assign Address  = address_q;
  assign opA      = opa_q;
  assign opB      = opb_q;
  assign opValid  = op_valid_q;
  assign emptyErr = empty_err_q;
  assign busy     = busy_q;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Sequencer directly downstream of the calculator's 8x32 operand SRAM.
- On a start pulse it drives the SRAM read port to fetch two stored operands, or one for unary operations, and captures the SRAM's registered dataOut.
- It presents the operand pair to the ALU stage with a valid/ready handshake.
- It flags a fetch whose slot was never loaded, using the SRAM's per-slot empty LEDs.

Parameters:
- DATA_W, 32, operand width (matches SRAM word).
- ADDR_W, 3, SRAM address width (8 slots).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to fetch; sampled only in IDLE.
- unary  in  1  1 = fetch operand A only; opB forced to 0.
- addrA  in  ADDR_W  slot of operand A.
- addrB  in  ADDR_W  slot of operand B.
- sramData  in  DATA_W  SRAM dataOut; registered, valid one cycle after Address/RD applied.
- slotEmpty  in  2**ADDR_W  SRAM led vector; bit=1 means slot empty/cleared.
- aluReady  in  1  ALU accepts operands.
- RD  out  1  SRAM read enable; 1 only while fetching.
- Address  out  ADDR_W  SRAM address.
- opA  out  DATA_W  captured operand A.
- opB  out  DATA_W  captured operand B.
- opValid  out  1  opA/opB/emptyErr valid.
- emptyErr  out  1  a referenced slot was empty at start.
- busy  out  1  high in any state but IDLE.

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - RD=0, Address=0, opA=0, opB=0, opValid=0, emptyErr=0, busy=0.
  - Internal latched addresses are cleared to 0.
  - Reset mid-fetch aborts with no partial opValid.
- All outputs are registered.
- FSM states: IDLE, REQ_A, CAP_A, CAP_B, VALID.
- IDLE:
  - On start=1, latch addrA, addrB and unary.
  - Compute emptyErr = slotEmpty[addrA] | (~unary & slotEmpty[addrB]) and register it.
  - Go to REQ_A with RD=1, Address=addrA.
  - Start=0: stay; RD=0.
- REQ_A: go to CAP_A.
  - If not unary: Address=latched addrB, RD=1.
  - If unary: RD=0.
- CAP_A:
  - Capture opA<=sramData, which is SRAM[addrA].
  - Unary: opB<=0; go to VALID with opValid=1.
  - Otherwise: RD<=0 and go to CAP_B.
- CAP_B: capture opB<=sramData, which is SRAM[addrB]; go to VALID with opValid=1.
- VALID:
  - opA, opB and emptyErr are held stable while opValid=1.
  - On a rising edge with aluReady=1: opValid<=0, busy<=0, go to IDLE.
  - opA/opB retain their values after the handoff.
- Latency:
  - Binary: start edge to opValid=1 is 4 clocks.
  - Unary: 3 clocks.
  - aluReady may be high before opValid; the handoff then completes on the first VALID cycle.
- start is ignored while busy=1, including when start and aluReady coincide in VALID; the request must be re-pulsed from IDLE.
- addrA==addrB is legal; both operands equal SRAM[addrA].
- emptyErr does not suppress the fetch; data is whatever the SRAM holds (0 after clear). The consumer decides what to do with it.
- RD is never 1 outside REQ_A/CAP_A. The block never writes the SRAM and drives no Load/Clear.

Test Plan:
- SRAM[2]=32'h0000_0007, SRAM[5]=32'h0000_0003, slotEmpty=8'b1101_1011, start with addrA=2, addrB=5, aluReady=1 -> opValid 4 clocks after start, opA=7, opB=3, emptyErr=0. Address sequence is 2,5; RD high for exactly 2 cycles; opValid high for 1 cycle.
- Unary fetch, addrA=2 -> opValid after 3 clocks, opA=7, opB=0, RD high 1 cycle.
- aluReady=0 for 5 cycles in VALID while start pulses -> opA/opB held, no new fetch. aluReady=1 -> IDLE next edge; the start pulse that coincided with it is ignored.
- Slot 6 cleared (slotEmpty[6]=1), fetch addrA=6, addrB=2 -> emptyErr=1, opA=0, opB=7.
- rst asserted during CAP_A -> RD, opValid, busy and the operands go to 0 immediately, without waiting for a clock edge. A new start after reset fetches correctly.
- addrA=addrB=5 -> opA=opB=3.
